// File: rtl/vc_output_ctrl_if.sv
// Bundles the two VC buffer read ports and the outbound link for vc_output_ctrl.
// The master modport is the controller; the slave modport is its environment.
interface vc_output_ctrl_if #(
  parameter int PAC_WIDTH = 64
);
  logic                 empty0;
  logic [PAC_WIDTH-1:0] d_in0;
  logic                 ren0;
  logic                 empty1;
  logic [PAC_WIDTH-1:0] d_in1;
  logic                 ren1;
  logic                 so;
  logic                 ri;
  logic [PAC_WIDTH-1:0] pdo;
  logic [15:0]          pkt_cnt;

  modport master (
    input  empty0, d_in0, empty1, d_in1, ri,
    output ren0, ren1, so, pdo, pkt_cnt
  );

  modport slave (
    output empty0, d_in0, empty1, d_in1, ri,
    input  ren0, ren1, so, pdo, pkt_cnt
  );
endinterface

// File: rtl/vc_output_ctrl.sv
// Output controller: round-robin pops two VC buffers into a single output
// register and hands packets to the link with a so/ri handshake.
module vc_output_ctrl #(
  parameter int PAC_WIDTH = 64
) (
  input logic             clk,
  input logic             reset,
  vc_output_ctrl_if.master bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 ptr;
  logic [PAC_WIDTH-1:0] pdo_q;
  logic [15:0]          cnt;
  logic                 transfer;
  logic                 load_ok;
  logic                 grant0;
  logic                 grant1;

  // Grants are gated by reset so no buffer is popped while reset is held.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    transfer   = (state == S_FULL) && bus.ri;
    load_ok    = (state == S_EMPTY) || transfer;
    if (reset && load_ok) begin
      if (!bus.empty0 && !bus.empty1) begin
        if (ptr) grant1 = 1'b1;
        else     grant0 = 1'b1;
      end else if (!bus.empty0) begin
        grant0 = 1'b1;
      end else if (!bus.empty1) begin
        grant1 = 1'b1;
      end
    end
    if (grant0 || grant1) state_next = S_FULL;
    else if (transfer)    state_next = S_EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // pdo keeps its last value when the register empties; only a grant reloads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pdo_q <= '0;
      ptr   <= 1'b0;
    end else begin
      if (grant0) begin
        pdo_q <= bus.d_in0;
        ptr   <= 1'b1;
      end else if (grant1) begin
        pdo_q <= bus.d_in1;
        ptr   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 16'h0000;
    end else if (transfer && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

  assign bus.ren0    = grant0;
  assign bus.ren1    = grant1;
  assign bus.so      = (state == S_FULL);
  assign bus.pdo     = pdo_q;
  assign bus.pkt_cnt = cnt;

endmodule

// File: tb/tb_vc_output_ctrl.sv
// Randomized bench for vc_output_ctrl: buffers are modelled as packet queues and
// the link side is predicted from the arbitration and handshake rules.
module tb_vc_output_ctrl;

  localparam int PAC_WIDTH = 64;

  logic clk;
  logic rst_n;

  vc_output_ctrl_if #(.PAC_WIDTH(PAC_WIDTH)) bus ();

  vc_output_ctrl #(.PAC_WIDTH(PAC_WIDTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  bit          model_full;
  logic [63:0] model_pdo;
  bit          model_ptr;
  int          model_cnt;
  int          ri_mode;
  int          checks;
  int          failures;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h time=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_full = 1'b0;
    model_pdo  = '0;
    model_ptr  = 1'b0;
    model_cnt  = 0;
  endtask

  function automatic logic [63:0] randPkt();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the pops,
  // then advance the model to the state expected after the coming rising edge.
  task automatic applyStimulus(input bit rst_val);
    int  g;
    bit  xfer;
    bit  ri_val;
    @(negedge clk);
    checkOutput("so", 64'(bus.so), 64'(model_full));
    checkOutput("pdo", bus.pdo, model_pdo);
    checkOutput("pkt_cnt", 64'(bus.pkt_cnt), 64'(model_cnt));
    rst_n = rst_val;
    if (!rst_val) modelReset();
    bus.empty0 = (q0.size() == 0);
    bus.d_in0  = (q0.size() != 0) ? q0[0] : randPkt();
    bus.empty1 = (q1.size() == 0);
    bus.d_in1  = (q1.size() != 0) ? q1[0] : randPkt();
    if (ri_mode == 0)      ri_val = 1'b0;
    else if (ri_mode == 1) ri_val = 1'b1;
    else                   ri_val = ($urandom_range(0, 3) != 0);
    bus.ri = ri_val;
    #1;
    g = 0;
    xfer = model_full && ri_val;
    if (rst_val && (!model_full || xfer)) begin
      if (q0.size() != 0 && q1.size() != 0) g = model_ptr ? 2 : 1;
      else if (q0.size() != 0)              g = 1;
      else if (q1.size() != 0)              g = 2;
    end
    checkOutput("ren0", 64'(bus.ren0), 64'(g == 1));
    checkOutput("ren1", 64'(bus.ren1), 64'(g == 2));
    if (rst_val) begin
      if (xfer) begin
        model_full = 1'b0;
        if (model_cnt < 65535) model_cnt++;
      end
      if (g == 1) begin
        model_pdo = q0.pop_front();
        model_ptr = 1'b1;
        model_full = 1'b1;
      end else if (g == 2) begin
        model_pdo = q1.pop_front();
        model_ptr = 1'b0;
        model_full = 1'b1;
      end
    end
  endtask

  // Asserts reset away from any clock edge and checks the immediate clear.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_so", 64'(bus.so), 64'd0);
    checkOutput("rst_pdo", bus.pdo, 64'd0);
    checkOutput("rst_cnt", 64'(bus.pkt_cnt), 64'd0);
    checkOutput("rst_ren", 64'({bus.ren0, bus.ren1}), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ri_mode  = 1;
    bus.empty0 = 1'b0;
    bus.empty1 = 1'b1;
    bus.d_in0  = 64'h1234;
    bus.d_in1  = '0;
    bus.ri     = 1'b1;
    rst_n      = 1'b1;
    modelReset();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("init_so", 64'(bus.so), 64'd0);
    checkOutput("init_pdo", bus.pdo, 64'd0);
    checkOutput("init_cnt", 64'(bus.pkt_cnt), 64'd0);
    checkOutput("init_ren0", 64'(bus.ren0), 64'd0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    // Single packet
    q0.push_back(64'hA5A5_0000_0000_0001);
    ri_mode = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    checkOutput("single_cnt", 64'(bus.pkt_cnt), 64'd1);

    // Backpressure for five cycles, then release
    q1.push_back(randPkt());
    ri_mode = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1);
    ri_mode = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);

    // Round-robin from a fresh reset, both buffers backlogged
    asyncReset();
    applyStimulus(1'b0);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(randPkt());
      q1.push_back(randPkt());
    end
    for (int i = 0; i < 18; i++) applyStimulus(1'b1);

    // Random traffic and random backpressure
    ri_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) q0.push_back(randPkt());
      if ($urandom_range(0, 2) == 0) q1.push_back(randPkt());
      applyStimulus(1'b1);
    end

    // Drain, then both buffers empty for a while
    ri_mode = 1;
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) applyStimulus(1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);
    checkOutput("drained_so", 64'(bus.so), 64'd0);

    // Reset while a packet is stalled in the output register
    q0.push_back(randPkt());
    ri_mode = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    q0.push_back(randPkt());
    q1.push_back(randPkt());
    asyncReset();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    ri_mode = 1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1);

    // Saturation of the packet counter
    asyncReset();
    applyStimulus(1'b0);
    for (int i = 0; i < 65545; i++) begin
      if (q0.size() < 2) q0.push_back(randPkt());
      if (q1.size() < 2) q1.push_back(randPkt());
      applyStimulus(1'b1);
    end
    applyStimulus(1'b1);
    checkOutput("sat_cnt", 64'(bus.pkt_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_output_ctrl.md
VC_OUTPUT_CTRL -- requirements
Module: vc_output_ctrl

Interface
REQ-001 SHALL have parameter PAC_WIDTH, default 64, packet width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port empty0  input  1  buffer 0 (even VC) empty flag.
REQ-005 SHALL have port d_in0  input  PAC_WIDTH  buffer 0 head packet, valid whenever empty0=0.
REQ-006 SHALL have port ren0  output  1  buffer 0 pop; head removed at the rising edge where ren0=1.
REQ-007 SHALL have ports empty1, d_in1, ren1, identical to REQ-004..006, for buffer 1 (odd VC).
REQ-008 SHALL have port so  output  1  link send-out valid, high while the output register holds a packet.
REQ-009 SHALL have port ri  input  1  link ready-in from downstream.
REQ-010 SHALL have port pdo  output  PAC_WIDTH  link packet data, from the output register.
REQ-011 SHALL have port pkt_cnt  output  16  count of packets transferred on the link, saturating.

Function
REQ-012 SHALL hold one output register (pdo) with occupancy flag driving so; states EMPTY (so=0) and FULL (so=1).
REQ-013 SHALL treat a link transfer as a rising edge with so=1 and ri=1.
REQ-014 SHALL define load_ok = (so=0) or (so=1 and ri=1).
REQ-015 SHALL grant one buffer per cycle only when load_ok=1 and at least one of empty0/empty1 is 0.
REQ-016 SHALL assert ren of the granted buffer combinationally in that cycle and SHALL load its d_in into pdo at the same edge.
REQ-017 SHALL never assert ren0 and ren1 in the same cycle.
REQ-018 SHALL never assert renX while emptyX=1.
REQ-019 SHALL arbitrate round-robin with a 1-bit priority pointer: if both buffers are non-empty, grant the pointer's buffer; if only one is non-empty, grant that one.
REQ-020 SHALL set the pointer to the non-granted buffer after every grant; with no grant the pointer is unchanged.
REQ-021 SHALL perform transfer and reload at the same edge when both apply, sustaining 1 packet/cycle with so held high.
REQ-022 SHALL go EMPTY (so=0) after a transfer with no grant.
REQ-023 SHALL keep pdo and so unchanged while so=1 and ri=0.
REQ-024 SHALL deliver a packet from a non-empty buffer with output EMPTY at cycle N (ren high at N) on the link with so=1 from cycle N+1.
REQ-025 SHALL increment pkt_cnt by 1 per transfer and saturate at 16'hFFFF.
REQ-026 SHALL ignore ri when so=0; pkt_cnt does not change.
REQ-027 SHALL leave pdo at its last value, not cleared, when going EMPTY.

Reset
REQ-028 SHALL, while reset=0, force so=0, pdo=0, pkt_cnt=0, pointer=buffer 0, ren0=ren1=0, regardless of clk.
REQ-029 SHALL discard a packet held in the output register when reset asserts mid-operation; buffers are not popped during reset.
REQ-030 SHALL, at the first rising edge after reset deasserts, be able to grant (ren may assert in that cycle).

Verification
REQ-031 SHALL cover single packet: after reset, empty0=0, d_in0=64'hA5A5_0000_0000_0001, ri=1 -> ren0=1 for exactly one cycle; next cycle so=1, pdo=that value; pkt_cnt=1 one edge later.
REQ-032 SHALL cover backpressure: packet loaded, ri=0 for 5 cycles -> so=1, pdo stable, ren0=ren1=0, pkt_cnt unchanged; ri=1 -> one transfer, pkt_cnt+1.
REQ-033 SHALL cover round-robin: both buffers continuously non-empty, ri=1 -> grants alternate 0,1,0,1 starting with 0; so stays high; pkt_cnt increments every cycle.
REQ-034 SHALL cover empty guard: empty0=empty1=1 for 10 cycles -> ren0=ren1=0; so drops to 0 after the held packet transfers.
REQ-035 SHALL cover reset mid-operation: reset=0 while so=1, ri=0, asynchronous to clk -> so=0, pdo=0, pkt_cnt=0 immediately; after release the first grant goes to buffer 0.
REQ-036 SHALL cover saturation: force 65536+ transfers -> pkt_cnt holds 16'hFFFF with no wrap to 0.
